// File: rtl/inst_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_if
// Purpose : Bundles the fetch-return handshake and the decode-side handshake
//           that surround the instruction fetch queue.
// Signals :
//   if_valid / if_pc / if_inst / if_ready  fetch return word and acceptance
//   id_valid / id_ready                    decode handshake on the head entry
//   id_pc / id_inst                        head entry PC and instruction word
//   id_op / id_rs / id_rt / id_funct       decoder field slices of id_inst
//   id_adel                                head PC misaligned (address error)
// Modports:
//   slave  : the queue itself (consumes fetch words, produces decode words)
//   master : the surrounding fetch unit / decoder (or a testbench)
// -----------------------------------------------------------------------------
interface inst_fetch_queue_if;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;

    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [5:0]  id_funct;
    logic        id_adel;

    modport slave (
        input  if_valid, if_pc, if_inst, id_ready,
        output if_ready, id_valid, id_pc, id_inst,
               id_op, id_rs, id_rt, id_funct, id_adel
    );

    modport master (
        output if_valid, if_pc, if_inst, id_ready,
        input  if_ready, id_valid, id_pc, id_inst,
               id_op, id_rs, id_rt, id_funct, id_adel
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// Purpose : Small circular FIFO between the instruction-side bus return and the
//           ID stage. Decouples fetch latency from decode stalls and supports a
//           single-cycle flush on branch redirect / exception / eret.
// Ports   :
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset (clears pointers and count)
//   flush      synchronous discard of all entries, highest priority
//   occupancy  current number of valid entries (PTR_W+1 bits)
//   bus        inst_fetch_queue_if.slave: fetch return in, decode head out
// Parameters:
//   DEPTH      number of entries, power of two, >= 2
//   PTR_W      log2(DEPTH)
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    output logic [PTR_W:0]        occupancy,
    inst_fetch_queue_if.slave     bus
);

    localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    // Entry layout: {adel, pc[31:0], inst[31:0]}
    localparam int C_ENTRY_W = 65;

    logic [C_ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_adel_in;
    logic [C_ENTRY_W-1:0] w_head;
    logic [31:0]          w_id_inst;

    // Handshake flags depend only on registered count, never on id_ready,
    // so a full queue refuses a push even when a pop happens the same cycle.
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    assign bus.if_ready = ~w_full;
    assign bus.id_valid = ~w_empty;

    // Flush suppresses both sides; the producer must treat its word as dropped.
    assign w_push = bus.if_valid & ~w_full  & ~flush;
    assign w_pop  = bus.id_ready & ~w_empty & ~flush;

    assign w_adel_in = (bus.if_pc[1:0] != 2'b00);

    // Pointer and count state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; stale contents are hidden by the
    // empty gating on the head outputs.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_adel_in, bus.if_pc, bus.if_inst};
        end
    end

    // Head read is combinational from rd_ptr; an empty queue presents a NOP
    // at PC 0 so the decoder sees clean zeros rather than stale data.
    assign w_head    = r_mem[r_rd_ptr];
    assign w_id_inst = w_empty ? 32'h0 : w_head[31:0];

    assign bus.id_inst  = w_id_inst;
    assign bus.id_pc    = w_empty ? 32'h0 : w_head[63:32];
    assign bus.id_adel  = w_empty ? 1'b0  : w_head[64];
    assign bus.id_op    = w_id_inst[31:26];
    assign bus.id_rs    = w_id_inst[25:21];
    assign bus.id_rt    = w_id_inst[20:16];
    assign bus.id_funct = w_id_inst[5:0];

    assign occupancy = r_count;

    // Structural invariants of the circular buffer
    a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
        r_count <= C_DEPTH);
    a_ptr_count: assert property (@(posedge clk) disable iff (!resetn)
        PTR_W'(r_wr_ptr - r_rd_ptr) == r_count[PTR_W-1:0]);
    a_no_push_full: assert property (@(posedge clk) disable iff (!resetn)
        !(w_push && w_full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!resetn)
        !(w_pop && w_empty));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
// Purpose : Self-checking bench for inst_fetch_queue. A queue-based reference
//           model predicts the head outputs, handshake flags and occupancy
//           every cycle; directed scenarios add fixed-value checks.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk;
    logic             resetn;
    logic             flush;
    logic [PTR_W:0]   occupancy;

    inst_fetch_queue_if bus ();

    inst_fetch_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .occupancy (occupancy),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each entry is {adel, pc, inst}, head at index 0.
    logic [64:0] model[$];

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_adel;
        if (model.size() == 0) begin
            e_inst = 32'h0;
            e_pc   = 32'h0;
            e_adel = 1'b0;
        end else begin
            e_inst = model[0][31:0];
            e_pc   = model[0][63:32];
            e_adel = model[0][64];
        end
        check_eq("id_valid",  bus.id_valid, model.size() != 0);
        check_eq("if_ready",  bus.if_ready, model.size() != DEPTH);
        check_eq("occupancy", occupancy,    model.size());
        check_eq("id_pc",     bus.id_pc,    e_pc);
        check_eq("id_inst",   bus.id_inst,  e_inst);
        check_eq("id_op",     bus.id_op,    e_inst >> 26);
        check_eq("id_rs",     bus.id_rs,    (e_inst >> 21) & 32'h1F);
        check_eq("id_rt",     bus.id_rt,    (e_inst >> 16) & 32'h1F);
        check_eq("id_funct",  bus.id_funct, e_inst & 32'h3F);
        check_eq("id_adel",   bus.id_adel,  e_adel);
    endtask

    // One clock cycle: apply inputs, check outputs away from the edge, then
    // advance the model with the rules for push, pop and flush.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
        bit do_push;
        bit do_pop;
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_inst  = ins;
        bus.id_ready = rdy;
        flush        = fl;
        @(negedge clk);
        check_outputs();
        do_push = v && (model.size() < DEPTH) && !fl;
        do_pop  = (model.size() != 0) && rdy && !fl;
        @(posedge clk);
        if (fl) begin
            model.delete();
        end else begin
            if (do_pop)  void'(model.pop_front());
            if (do_push) model.push_back({(pc[1:0] != 2'b00), pc, ins});
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn       = 1'b0;
        flush        = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_pc    = 32'h0;
        bus.if_inst  = 32'h0;
        bus.id_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state
        idle(1'b0);

        // Mid-cycle asynchronous reset drops queued entries at once
        cyc(1'b1, 32'hBFC0_0100, 32'h1111_1111, 1'b0, 1'b0);
        cyc(1'b1, 32'hBFC0_0104, 32'h2222_2222, 1'b0, 1'b0);
        #3 resetn = 1'b0;
        #1;
        model.delete();
        check_eq("rst_id_valid",  bus.id_valid, 1'b0);
        check_eq("rst_if_ready",  bus.if_ready, 1'b1);
        check_eq("rst_occupancy", occupancy,    0);
        check_eq("rst_id_inst",   bus.id_inst,  32'h0);
        check_eq("rst_id_op",     bus.id_op,    6'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        idle(1'b0);

        // Single addiu word
        cyc(1'b1, 32'hBFC0_0000, 32'h2408_0005, 1'b0, 1'b0);
        check_eq("single_valid", bus.id_valid, 1'b1);
        check_eq("single_op",    bus.id_op,    6'h09);
        check_eq("single_rs",    bus.id_rs,    5'd0);
        check_eq("single_rt",    bus.id_rt,    5'd8);
        check_eq("single_funct", bus.id_funct, 6'h05);
        check_eq("single_adel",  bus.id_adel,  1'b0);
        drain();

        // Fill and stall: fifth word refused
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'hBFC0_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
            if (i == 3) check_eq("fill_if_ready_full", bus.if_ready, 1'b0);
        end
        check_eq("fill_occupancy", occupancy, 4);
        for (int k = 0; k < 4; k++) begin
            check_eq("fill_order_pc", bus.id_pc, 32'hBFC0_0000 + 32'(4 * k));
            idle(1'b1);
        end
        check_eq("fill_empty", bus.id_valid, 1'b0);

        // Wrap and concurrency at count 2
        cyc(1'b1, 32'h0000_1000, 32'hB000_0000, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_1004, 32'hB000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h0000_1008 + 32'(4 * i), 32'hB000_0002 + 32'(i), 1'b1, 1'b0);
            check_eq("wrap_occupancy", occupancy, 2);
        end
        drain();

        // Flush with concurrent push and pop
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h0000_2000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_200C, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check_eq("flush_occupancy", occupancy,    0);
        check_eq("flush_id_valid",  bus.id_valid, 1'b0);
        check_eq("flush_if_ready",  bus.if_ready, 1'b1);
        idle(1'b1);

        // Misaligned fetch followed by aligned one
        cyc(1'b1, 32'hBFC0_0002, 32'h0000_0001, 1'b0, 1'b0);
        cyc(1'b1, 32'hBFC0_0004, 32'h0000_0002, 1'b0, 1'b0);
        check_eq("adel_set", bus.id_adel, 1'b1);
        idle(1'b1);
        check_eq("adel_clear", bus.id_adel, 1'b0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
